debug_action_arbiter: RTL and testbench

DEBUG_ACTION_ARBITER -- requirements
Module: debug_action_arbiter

---
 rtl/debug_action_arbiter.sv | 166 ++++++++++++++++
 tb/tb_debug_action_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_action_arbiter.sv
// debug_action_arbiter: latches six single-cycle debug action strobes and
// serialises them onto the OCI register port, slot 0 highest priority.
// Optional feature macro DEBUG_ARB_TIMEOUT_EN: abandon an access when no ack
// arrives within TIMEOUT cycles and raise the sticky err_timeout flag.
module debug_action_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_action_break_a,
  input  logic        take_action_break_b,
  input  logic        take_action_break_c,
  input  logic        take_action_tracectrl,
  input  logic        oci_ack,
  input  logic [31:0] oci_rdata,
  input  logic        err_clr,
  output logic        oci_req,
  output logic        oci_we,
  output logic [8:0]  oci_addr,
  output logic [31:0] oci_wdata,
  output logic [31:0] mon_rdata,
  output logic        mon_ready,
  output logic        busy,
  output logic [5:0]  pending,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int unsigned NSLOT     = 6;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned PAY_W     = 38;
  localparam int unsigned READ_SLOT = 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] grant_q, grant_d;
  logic [PAY_W-1:0]  payload_q [NSLOT];
  logic [NSLOT-1:0]  strobe;
  logic [NSLOT-1:0]  retire_vec;
  logic              load;
  logic              retire;
  logic              tmo_expired;
  logic              overrun_set;

  assign strobe = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                   take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};

  assign retire_vec  = retire ? (NSLOT'(1) << grant_q) : '0;
  // A strobe landing on the slot being retired re-arms it instead of overrunning
  assign overrun_set = |(strobe & pending & ~retire_vec);

  // Next-state and fixed-priority grant selection
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    load    = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          load    = 1'b1;
          state_d = REQ;
          for (int i = int'(NSLOT) - 1; i >= 0; i--) begin
            if (pending[i]) grant_d = SLOT_W'(i);
          end
        end
      end
      REQ: begin
        if (oci_ack || tmo_expired) begin
          retire  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and grant registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Per-slot pending flags and payload capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int i = 0; i < int'(NSLOT); i++) payload_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NSLOT); i++) begin
        if (strobe[i]) begin
          pending[i]   <= 1'b1;
          payload_q[i] <= jdo;
        end else if (retire_vec[i]) begin
          pending[i]   <= 1'b0;
        end
      end
    end
  end

  // OCI port and monitor outputs, registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oci_req   <= 1'b0;
      oci_we    <= 1'b0;
      oci_addr  <= '0;
      oci_wdata <= '0;
      mon_rdata <= '0;
      mon_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      oci_req   <= (state_d == REQ);
      mon_ready <= (state_d == DONE);
      busy      <= (state_d != IDLE);
      if (load) begin
        oci_addr  <= {grant_d, payload_q[grant_d][37:32]};
        oci_wdata <= payload_q[grant_d][31:0];
        oci_we    <= (grant_d != SLOT_W'(READ_SLOT));
      end
      if ((state_q == REQ) && oci_ack && !oci_we) mon_rdata <= oci_rdata;
    end
  end

  // Sticky overrun flag; a new overrun outranks err_clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            err_overrun <= 1'b0;
    else if (overrun_set) err_overrun <= 1'b1;
    else if (err_clr)     err_overrun <= 1'b0;
  end

`ifdef DEBUG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_expired = (state_q == REQ) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Cycles spent waiting for ack in the current access
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                tmo_cnt <= '0;
    else if (state_q == REQ)  tmo_cnt <= tmo_cnt + CNT_W'(1);
    else                      tmo_cnt <= '0;
  end

  // Sticky timeout flag; ack in the final cycle still counts as success
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       err_timeout <= 1'b0;
    else if (tmo_expired && !oci_ack) err_timeout <= 1'b1;
    else if (err_clr)                err_timeout <= 1'b0;
  end
`else
  assign tmo_expired = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_debug_action_arbiter.sv
// Bench for debug_action_arbiter: table of single accesses plus hand sequences
// for priority, overrun, same-cycle re-arm, timeout and reset mid-access.
module tb_debug_action_arbiter;

  localparam int unsigned TMO     = 4;
  localparam logic [31:0] RD_LAST = 32'h0BADF00D;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic [5:0]  strb;
  logic        oci_ack;
  logic [31:0] oci_rdata;
  logic        err_clr;
  logic        oci_req, oci_we, mon_ready, busy, err_overrun, err_timeout;
  logic [8:0]  oci_addr;
  logic [31:0] oci_wdata, mon_rdata;
  logic [5:0]  pending;

  debug_action_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(strb[0]), .take_action_ocimem_b(strb[1]),
    .take_action_break_a(strb[2]), .take_action_break_b(strb[3]),
    .take_action_break_c(strb[4]), .take_action_tracectrl(strb[5]),
    .oci_ack(oci_ack), .oci_rdata(oci_rdata), .err_clr(err_clr),
    .oci_req(oci_req), .oci_we(oci_we), .oci_addr(oci_addr), .oci_wdata(oci_wdata),
    .mon_rdata(mon_rdata), .mon_ready(mon_ready), .busy(busy), .pending(pending),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [37:0] jdo;
    int          ack_dly;
    logic [31:0] rdata;
    logic [8:0]  exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [8:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [8:0] a, input logic w, input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.addr = a; e.we = w; e.wdata = wd; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!oci_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_req", 64'(oci_req), 64'(1));
  endtask

  task automatic serve(input int ack_dly, input logic [31:0] rd);
    wait_req();
    repeat (ack_dly) @(negedge clk);
    check("req_held", 64'(oci_req), 64'(1));
    oci_ack = 1'b1; oci_rdata = rd;
    @(negedge clk);
    oci_ack = 1'b0; oci_rdata = 32'h0;
    check("done_ready", 64'(mon_ready), 64'(1));
    check("done_req_low", 64'(oci_req), 64'(0));
  endtask

  // Scoreboard: pop an expectation on each rising oci_req, check read data on mon_ready
  initial begin
    exp_t cur;
    bit   have_cur = 1'b0;
    logic req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        have_cur = 1'b0;
        req_prev = 1'b0;
      end else begin
        if (oci_req && !req_prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_unexpected_req: got addr 0x%0h, expected no access", oci_addr);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            check("sb_addr", 64'(oci_addr), 64'(cur.addr));
            check("sb_we", 64'(oci_we), 64'(cur.we));
            check("sb_wdata", 64'(oci_wdata), 64'(cur.wdata));
          end
        end
        if (mon_ready) begin
          if (!have_cur) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_unexpected_ready: got mon_ready=1, expected 0");
          end else begin
            check("sb_mon_rdata", 64'(mon_rdata), 64'(cur.rdata));
            have_cur = 1'b0;
          end
        end
        req_prev = oci_req;
      end
    end
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [7];
    logic [5:0] one_hot;
    int         cnt;

    vecs[0] = '{2, 38'h2A_DEADBEEF, 3, 32'hFFFF_FFFF, 9'h0AA, 1'b1, 32'hDEADBEEF, 32'h0000_0000};
    vecs[1] = '{1, 38'h05_CAFEF00D, 0, 32'h1234_5678, 9'h045, 1'b0, 32'hCAFEF00D, 32'h1234_5678};
    vecs[2] = '{0, 38'h3F_00000001, 1, 32'hAAAA_AAAA, 9'h03F, 1'b1, 32'h0000_0001, 32'h1234_5678};
    vecs[3] = '{5, 38'h00_A5A5A5A5, 2, 32'h5555_5555, 9'h140, 1'b1, 32'hA5A5A5A5, 32'h1234_5678};
    vecs[4] = '{1, 38'h3F_FFFFFFFF, 0, RD_LAST,       9'h07F, 1'b0, 32'hFFFFFFFF, RD_LAST};
    vecs[5] = '{3, 38'h10_13572468, 1, 32'h0000_0000, 9'h0D0, 1'b1, 32'h13572468, RD_LAST};
    vecs[6] = '{4, 38'h01_00000000, 0, 32'h7777_7777, 9'h101, 1'b1, 32'h0000_0000, RD_LAST};

    reset = 1'b1; jdo = '0; strb = '0; oci_ack = 1'b0; oci_rdata = '0; err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 64'(oci_req), 64'(0));
    check("rst_addr", 64'(oci_addr), 64'(0));
    check("rst_pending", 64'(pending), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mon_rdata", 64'(mon_rdata), 64'(0));
    check("rst_errs", 64'({err_overrun, err_timeout}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single accesses from the table: latency, decode, read capture
    for (int k = 0; k < 7; k++) begin
      strb[vecs[k].slot] = 1'b1;
      jdo = vecs[k].jdo;
      push(vecs[k].exp_addr, vecs[k].exp_we, vecs[k].exp_wdata, vecs[k].exp_rdata);
      @(negedge clk);
      strb = '0;
      one_hot = 6'(1) << vecs[k].slot;
      check("n1_pending", 64'(pending), 64'(one_hot));
      check("n1_req_low", 64'(oci_req), 64'(0));
      @(negedge clk);
      check("n2_req_high", 64'(oci_req), 64'(1));
      check("n2_busy", 64'(busy), 64'(1));
      serve(vecs[k].ack_dly, vecs[k].rdata);
      @(negedge clk);
      check("idle_ready_low", 64'(mon_ready), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_pending", 64'(pending), 64'(0));
    end

    // Priority: slots 0 and 5 together
    strb = 6'h21; jdo = 38'h07_11111111;
    push(9'h007, 1'b1, 32'h11111111, RD_LAST);
    push(9'h147, 1'b1, 32'h11111111, RD_LAST);
    @(negedge clk);
    strb = '0;
    check("prio_pending_21", 64'(pending), 64'(6'h21));
    serve(0, 32'h0);
    check("prio_pending_20", 64'(pending), 64'(6'h20));
    serve(1, 32'h0);
    check("prio_pending_00", 64'(pending), 64'(6'h00));
    @(negedge clk);

    // Overrun: slot 3 strobed twice while slot 0 is stalled; set beats err_clr
    strb[0] = 1'b1; jdo = 38'h00_00000000;
    push(9'h000, 1'b1, 32'h0, RD_LAST);
    @(negedge clk);
    strb = '0;
    wait_req();
    strb[3] = 1'b1; jdo = 38'h01_AAAA0001;
    @(negedge clk);
    check("ovr_not_yet", 64'(err_overrun), 64'(0));
    strb[3] = 1'b1; jdo = 38'h02_BBBB0002; err_clr = 1'b1;
    push(9'h0C2, 1'b1, 32'hBBBB0002, RD_LAST);
    @(negedge clk);
    strb = '0; err_clr = 1'b0;
    check("ovr_set", 64'(err_overrun), 64'(1));
    check("ovr_pending", 64'(pending), 64'(6'h09));
    serve(0, 32'h0);
    check("ovr_pending_after0", 64'(pending), 64'(6'h08));
    serve(0, 32'h0);
    check("ovr_sticky", 64'(err_overrun), 64'(1));
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr_cleared", 64'(err_overrun), 64'(0));

    // Strobe on the slot being retired re-arms it without overrun
    strb[4] = 1'b1; jdo = 38'h00_11110000;
    push(9'h100, 1'b1, 32'h11110000, RD_LAST);
    @(negedge clk);
    strb = '0;
    wait_req();
    oci_ack = 1'b1; strb[4] = 1'b1; jdo = 38'h01_22220000;
    push(9'h101, 1'b1, 32'h22220000, RD_LAST);
    @(negedge clk);
    oci_ack = 1'b0; strb = '0;
    check("rearm_ready", 64'(mon_ready), 64'(1));
    check("rearm_pending", 64'(pending), 64'(6'h10));
    check("rearm_no_ovr", 64'(err_overrun), 64'(0));
    serve(0, 32'h0);
    check("rearm_pending_done", 64'(pending), 64'(0));
    @(negedge clk);

    // Missing ack: timeout when enabled, indefinite wait otherwise
    strb[5] = 1'b1; jdo = 38'h00_00000055;
    push(9'h140, 1'b1, 32'h55, RD_LAST);
    @(negedge clk);
    strb = '0;
    wait_req();
`ifdef DEBUG_ARB_TIMEOUT_EN
    cnt = 0;
    while (oci_req && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_req_cycles", 64'(cnt), 64'(TMO));
    check("tmo_ready", 64'(mon_ready), 64'(1));
    check("tmo_err", 64'(err_timeout), 64'(1));
    check("tmo_pending", 64'(pending), 64'(0));
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tmo_cleared", 64'(err_timeout), 64'(0));
`else
    cnt = 0;
    repeat (10) @(negedge clk);
    check("notmo_req_held", 64'(oci_req), 64'(1));
    check("notmo_err", 64'(err_timeout), 64'(0));
    serve(0, 32'h0);
    @(negedge clk);
`endif

    // Reset while an access is outstanding
    strb[2] = 1'b1; jdo = 38'h2A_DEADBEEF;
    push(9'h0AA, 1'b1, 32'hDEADBEEF, RD_LAST);
    @(negedge clk);
    strb = '0;
    wait_req();
    reset = 1'b1;
    #1;
    check("rreq_req_async", 64'(oci_req), 64'(0));
    check("rreq_pending", 64'(pending), 64'(0));
    check("rreq_busy", 64'(busy), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rreq_no_ready", 64'(mon_ready), 64'(0));
    end
    check("rreq_mon_rdata", 64'(mon_rdata), 64'(0));
    check("rreq_errs", 64'({err_overrun, err_timeout}), 64'(0));
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
